// File: rtl/aibcr3_dcc_cal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : aibcr3_dcc_cal_pkg                                           |
// | Description : Shared types and helpers for the DCC/DLL delay-code          |
// |               calibration controller (state encoding, gray conversion,     |
// |               settle-counter width helper).                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aibcr3_dcc_cal_pkg;

    // Controller states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAR   = 2'd1,
        TRACK = 2'd2
    } cal_state_t;

    // Binary to reflected-binary gray; callers cast the result to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

    // Width of a counter that must hold the values 0..settle inclusive.
    // The settle-cycle count is a module parameter, so the package supplies the
    // rule and each user derives its own SET_W localparam from it.
    function automatic int set_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage : aibcr3_dcc_cal_pkg
`default_nettype wire

// File: rtl/aibcr3_dcc_updn_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aibcr3_dcc_updn_filter                                       |
// | Description : Signed up/down accumulator for tracking-mode PD samples.     |
// |               Emits a single-cycle step request when the running sum       |
// |               reaches +FILT_DEPTH or -FILT_DEPTH, then restarts from 0.    |
// | Ports       : clk_dcd, dll_reset_n (async active-low)                      |
// |               i_clr    - hold accumulator at zero                          |
// |               i_sample - one PD sample is presented this cycle             |
// |               i_up/i_down - PD decision for the sample                     |
// |               o_step_up/o_step_dn - threshold reached (combinational)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aibcr3_dcc_updn_filter #(
    parameter int FILT_DEPTH = 8
) (
    input  logic clk_dcd,
    input  logic dll_reset_n,
    input  logic i_clr,
    input  logic i_sample,
    input  logic i_up,
    input  logic i_down,
    output logic o_step_up,
    output logic o_step_dn
);

    // Two spare bits: one for sign, one so +FILT_DEPTH itself is representable.
    localparam int ACC_W = $clog2(FILT_DEPTH) + 2;
    localparam logic signed [ACC_W-1:0] c_pos_lim = ACC_W'(FILT_DEPTH);
    localparam logic signed [ACC_W-1:0] c_neg_lim = -c_pos_lim;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W-1:0] w_acc_nxt;

    // Conflicting flags carry no direction information and leave the sum alone.
    always_comb begin
        w_delta = '0;
        if (i_up && !i_down) begin
            w_delta = ACC_W'(1);
        end else if (i_down && !i_up) begin
            w_delta = -ACC_W'(1);
        end
    end

    assign w_acc_nxt = r_acc + w_delta;
    assign o_step_up = i_sample && (w_acc_nxt == c_pos_lim);
    assign o_step_dn = i_sample && (w_acc_nxt == c_neg_lim);

    always_ff @(posedge clk_dcd or negedge dll_reset_n) begin
        if (!dll_reset_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_sample) begin
            if (o_step_up || o_step_dn) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_nxt;
            end
        end
    end

endmodule : aibcr3_dcc_updn_filter
`default_nettype wire

// File: rtl/aibcr3_dcc_cal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aibcr3_dcc_cal_ctrl                                          |
// | Description : DCC/DLL delay-code calibration controller. Runs a one-shot   |
// |               SAR search on phase-detector decisions, then optional +/-1   |
// |               tracking, with a bypass/override path. Output code is gray.  |
// | Config      : AIBCR3_DCC_CAL_FILTER_EN - when defined, tracking steps are  |
// |               filtered by aibcr3_dcc_updn_filter (threshold FILT_DEPTH);   |
// |               otherwise every tracking sample may step the code.           |
// | Ports       : clk_dcd, dll_reset_n (async active-low)                      |
// |               cal_en, rb_cont_cal, rb_dcc_byp, rb_code[CODE_W]             |
// |               t_up, t_down (PD, synchronous to clk_dcd)                    |
// |               code_gray[CODE_W], cal_done, cal_err (sticky)                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aibcr3_dcc_cal_ctrl
    import aibcr3_dcc_cal_pkg::*;
#(
    parameter int CODE_W     = 11,
    parameter int SETTLE_CYC = 4,
    parameter int FILT_DEPTH = 8
) (
    input  logic              clk_dcd,
    input  logic              dll_reset_n,
    input  logic              cal_en,
    input  logic              rb_cont_cal,
    input  logic              rb_dcc_byp,
    input  logic [CODE_W-1:0] rb_code,
    input  logic              t_up,
    input  logic              t_down,
    output logic [CODE_W-1:0] code_gray,
    output logic              cal_done,
    output logic              cal_err
);

    localparam int SET_W = set_width(SETTLE_CYC);
    localparam int IDX_W = (CODE_W < 2) ? 1 : $clog2(CODE_W);

    localparam logic [SET_W-1:0]  c_set_last = SET_W'(SETTLE_CYC);
    localparam logic [IDX_W-1:0]  c_idx_msb  = IDX_W'(CODE_W - 1);
    localparam logic [CODE_W-1:0] c_one      = CODE_W'(1);
    localparam logic [CODE_W-1:0] c_code_msb = c_one << (CODE_W - 1);
    localparam logic [CODE_W-1:0] c_code_max = {CODE_W{1'b1}};

    // Elaboration-time parameter sanity.
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("aibcr3_dcc_cal_ctrl: SETTLE_CYC must be >= 1");
    end
    if ((FILT_DEPTH < 2) || ((FILT_DEPTH & (FILT_DEPTH - 1)) != 0)) begin : g_bad_filt
        $error("aibcr3_dcc_cal_ctrl: FILT_DEPTH must be a power of 2, >= 2");
    end

    cal_state_t        r_state, w_state_nxt;
    logic [CODE_W-1:0] r_code_bin, w_code_nxt;
    logic [CODE_W-1:0] r_code_gray;
    logic [IDX_W-1:0]  r_bit_idx, w_idx_nxt;
    logic [SET_W-1:0]  r_set_cnt, w_cnt_nxt;
    logic              r_cal_done, w_done_nxt;
    logic              r_cal_err, w_err_nxt;

    logic              w_tick;
    logic              w_both;
    logic              w_down_only;
    logic              w_trk_sample;
    logic [CODE_W-1:0] w_trial_bit;
    logic              w_step_up;
    logic              w_step_dn;
    logic [CODE_W-1:0] w_gray_nxt;

    // The PD is only trusted once the code has settled for SETTLE_CYC cycles.
    assign w_tick       = (r_set_cnt == c_set_last);
    assign w_both       = t_up && t_down;
    assign w_down_only  = t_down && !t_up;
    assign w_trial_bit  = c_one << r_bit_idx;
    assign w_trk_sample = (r_state == TRACK) && w_tick && rb_cont_cal;

`ifdef AIBCR3_DCC_CAL_FILTER_EN
    // Accumulator is held clear outside TRACK so each tracking phase starts at 0.
    aibcr3_dcc_updn_filter #(
        .FILT_DEPTH (FILT_DEPTH)
    ) u_updn_filter (
        .clk_dcd     (clk_dcd),
        .dll_reset_n (dll_reset_n),
        .i_clr       (r_state != TRACK),
        .i_sample    (w_trk_sample),
        .i_up        (t_up),
        .i_down      (t_down),
        .o_step_up   (w_step_up),
        .o_step_dn   (w_step_dn)
    );
`else
    assign w_step_up = w_trk_sample && t_up && !t_down;
    assign w_step_dn = w_trk_sample && t_down && !t_up;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code_bin;
        w_idx_nxt   = r_bit_idx;
        w_cnt_nxt   = r_set_cnt;
        w_done_nxt  = r_cal_done;
        w_err_nxt   = r_cal_err;

        if (rb_dcc_byp) begin
            // Override wins over everything and parks the FSM until released.
            w_state_nxt = IDLE;
            w_code_nxt  = rb_code;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
        end else if (!cal_en) begin
            // Abort: code is held, only the done flag drops.
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SAR;
                    w_idx_nxt   = c_idx_msb;
                    w_code_nxt  = c_code_msb;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                end
                SAR: begin
                    if (w_tick) begin
                        w_cnt_nxt = '0;
                        if (w_both) begin
                            w_err_nxt = 1'b1;
                        end
                        // Decide the current trial bit and plant the next lower
                        // one in the same cycle; at bit 0 the shift yields 0.
                        w_code_nxt = (r_code_bin & ~(w_down_only ? w_trial_bit : '0))
                                   | (w_trial_bit >> 1);
                        if (r_bit_idx == '0) begin
                            w_state_nxt = TRACK;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_bit_idx - 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_set_cnt + 1'b1;
                    end
                end
                TRACK: begin
                    w_done_nxt = 1'b1;
                    if (w_tick) begin
                        w_cnt_nxt = '0;
                        if (w_both) begin
                            w_err_nxt = 1'b1;
                        end
                        // Saturating +/-1; the step requests already include the
                        // rb_cont_cal gate.
                        if (w_step_up && (r_code_bin != c_code_max)) begin
                            w_code_nxt = r_code_bin + 1'b1;
                        end else if (w_step_dn && (r_code_bin != '0)) begin
                            w_code_nxt = r_code_bin - 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_set_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign w_gray_nxt = CODE_W'(bin2gray(32'(w_code_nxt)));

    always_ff @(posedge clk_dcd or negedge dll_reset_n) begin
        if (!dll_reset_n) begin
            r_state     <= IDLE;
            r_code_bin  <= '0;
            r_code_gray <= '0;
            r_bit_idx   <= '0;
            r_set_cnt   <= '0;
            r_cal_done  <= 1'b0;
            r_cal_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code_bin  <= w_code_nxt;
            r_code_gray <= w_gray_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_set_cnt   <= w_cnt_nxt;
            r_cal_done  <= w_done_nxt;
            r_cal_err   <= w_err_nxt;
        end
    end

    assign code_gray = r_code_gray;
    assign cal_done  = r_cal_done;
    assign cal_err   = r_cal_err;

endmodule : aibcr3_dcc_cal_ctrl
`default_nettype wire
